pipelined_csel_subtractor: RTL
==============================

# pipelined_csel_subtractor

Pipelined 32-bit subtractor computing A − B as A + ~B + 1. The datapath is split into 8-bit carry-select slices, one slice per pipeline stage, with operands skewed between stages. It is the inverse-operation companion to the combinational carry-select adder in the ALU datapath. It provides a registered subtract path with valid/ready flow control, a borrow flag, a signed-overflow flag and a zero flag.

## Interface

- WIDTH, 32: operand/result width; must be a multiple of SLICE.
- SLICE, 8: bits resolved per pipeline stage; stage count N = WIDTH/SLICE (default 4).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block accepts operands this cycle.
- A  in  WIDTH  minuend.
- B  in  WIDTH  subtrahend.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result this cycle.
- Diff  out  WIDTH  A − B modulo 2^WIDTH.
- Borrow  out  1  1 when unsigned A < B (inverted final carry).
- Ovf  out  1  signed overflow: A[MSB] != B[MSB] and Diff[MSB] != A[MSB].
- Zero  out  1  Diff == 0.

## Operation

- **Handshake.** Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- **Global advance enable.** adv = !out_valid || out_ready. in_ready = adv, combinational, no dependency on in_valid.
- **Stage registers.** Stage k (k = 0..N−1) holds:
  - a valid bit;
  - the remaining unprocessed operand slices k..N−1 (A and ~B);
  - the already-resolved low result slices 0..k−1;
  - the carry out of slice k−1. Stage 0's carry-in is constant 1.
- **Per-stage computation.** Each stage computes slice k twice, once with carry-in 0 and once with carry-in 1, using ripple slices. It muxes sum and carry by the registered incoming carry, then registers the result into stage k+1.
- **Final stage.** The final stage registers Diff, the final carry C, and the two operand MSBs needed for Ovf. Borrow = ~C. Zero and Ovf are derived from registered values; they may be combinational from output registers.
- **Stall behaviour.** When adv = 0, every stage holds value and valid bit. No data is lost or duplicated.
- **Bubbles.** An invalid stage still shifts when adv = 1. Bubbles move forward; they do not collapse while stalled.
- **Payload updates.** Payload registers update only when adv = 1. Payload of invalid stages is don't-care except at the output (see reset).
- **Flag coherence.** Borrow, Ovf and Zero always belong to the same transaction as Diff.

## Timing

- **Reset.** Reset (rst_n low at a clock edge) clears all valid bits.
  - Output values: out_valid = 0, Diff = 0, Borrow = 0, Ovf = 0, Zero = 0 (Zero forced low while !out_valid).
  - in_ready = 1 from the first cycle after reset.
- **Reset mid-operation.** All in-flight transactions are discarded. No out_valid pulse follows reset.
- **Latency.** Operands accepted at edge t produce out_valid = 1 after edge t+N (default: 4 cycles), given no stall.
- **Throughput.** One transaction per cycle sustained while out_ready = 1.
- **Output stability.** While out_valid && !out_ready, Diff and all flags stay stable, and in_ready = 0.
- **Simultaneous events.** Output transfer and input acceptance in the same cycle are legal and required for full throughput.
- **Arithmetic rules.**
  - All arithmetic is modulo 2^WIDTH.
  - The carry chain spans slice boundaries only via the registered inter-stage carry.
  - Critical path is one SLICE-bit ripple plus one mux.

## Test plan

- **Reset.** Reset, then idle 10 cycles -> out_valid = 0, Diff = 0, all flags 0, in_ready = 1.
- **Basic subtracts.**
  - A = 5, B = 3 -> after 4 cycles: Diff = 0x00000002, Borrow = 0, Ovf = 0, Zero = 0.
  - A = 3, B = 5 -> Diff = 0xFFFFFFFE, Borrow = 1, Ovf = 0.
  - A = B = 0x12345678 -> Diff = 0, Zero = 1, Borrow = 0.
- **Cross-slice borrow and signed overflow.**
  - A = 0x01000000, B = 1 -> Diff = 0x00FFFFFF, Borrow = 0 (borrow ripples through three stages).
  - A = 0x80000000, B = 1 -> Diff = 0x7FFFFFFF, Ovf = 1, Borrow = 0.
  - A = 0x7FFFFFFF, B = 0xFFFFFFFF -> Diff = 0x80000000, Ovf = 1, Borrow = 1.
- **Throughput and ordering.** Stream 100 back-to-back random pairs with out_ready = 1 -> one result per cycle, in order, all matching the reference model.
- **Backpressure.** Hold out_ready = 0 for 6 cycles with a full pipeline -> in_ready = 0, output stable. Release -> results resume in order with no loss or duplication. Random in_valid/out_ready toggling over 1000 transactions -> scoreboard clean.
- **Reset mid-flight.** Assert rst_n = 0 with 3 transactions in flight -> no out_valid afterwards. A new transaction A = 10, B = 4 -> Diff = 6 after 4 cycles.

Source files
------------

// File: rtl/pipelined_csel_subtractor_if.sv
// Operand/result bus for the pipelined carry-select subtractor.
// master = producer/consumer side, slave = subtractor side.
interface pipelined_csel_subtractor_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Diff;
  logic             Borrow;
  logic             Ovf;
  logic             Zero;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, Diff, Borrow, Ovf, Zero
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, Diff, Borrow, Ovf, Zero
  );
endinterface

// File: rtl/pipelined_csel_subtractor.sv
// Pipelined A - B (= A + ~B + 1): one carry-select slice per stage, operands
// skewed so each stage only carries the slices it has not yet resolved.

module csel_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W:0] r0, r1;

  // Both carry-in cases resolve in parallel; the registered carry only picks.
  assign r0 = {1'b0, a} + {1'b0, b};
  assign r1 = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, 1'b1};
  assign {cout, sum} = cin ? r1 : r0;
endmodule

module pipelined_csel_subtractor #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input logic                        clk,
  input logic                        rst_n,
  pipelined_csel_subtractor_if.slave bus
);
  localparam int N = WIDTH / SLICE;

  logic                       adv;
  logic [N:0]                 vld_pipe;
  logic [N-1:0][SLICE-1:0]    sl_a, sl_b, sl_sum;
  logic [N-1:0]               sl_cin, sl_cout;

  logic [WIDTH-1:0]           diff_d;
  logic [WIDTH-1:0]           diff_q;
  logic                       c_q, a_msb_q, b_msb_q;

  assign adv          = !vld_pipe[N] || bus.out_ready;
  assign bus.in_ready = adv;

  // vld_pipe[k] tags stage k; vld_pipe[N] is the output register.
  always_ff @(posedge clk) begin
    if (!rst_n)   vld_pipe <= '0;
    else if (adv) vld_pipe <= {vld_pipe[N-1:0], bus.in_valid};
  end

  csel_slice #(.W(SLICE)) u_slice [N-1:0] (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (sl_cin),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  for (genvar k = 0; k < N; k++) begin : g_stg
    localparam int REM = (N - k) * SLICE;

    // Unresolved slices k..N-1, low-aligned: slice k always sits at the bottom.
    logic [REM-1:0] a_q;
    logic [REM-1:0] nb_q;
    logic           cy;

    assign sl_a[k]   = a_q[SLICE-1:0];
    assign sl_b[k]   = nb_q[SLICE-1:0];
    assign sl_cin[k] = cy;

    if (k == 0) begin : g_head
      assign cy = 1'b1;
      always_ff @(posedge clk) begin
        if (adv) begin
          a_q  <= bus.A;
          nb_q <= ~bus.B;
        end
      end
    end else begin : g_body
      logic [k*SLICE-1:0] res_q;
      logic [k*SLICE-1:0] res_d;

      if (k == 1) begin : g_first
        assign res_d = sl_sum[0];
      end else begin : g_next
        assign res_d = {sl_sum[k-1], g_stg[k-1].g_body.res_q};
      end

      always_ff @(posedge clk) begin
        if (adv) begin
          a_q   <= g_stg[k-1].a_q[REM+SLICE-1:SLICE];
          nb_q  <= g_stg[k-1].nb_q[REM+SLICE-1:SLICE];
          cy    <= sl_cout[k-1];
          res_q <= res_d;
        end
      end
    end
  end

  if (N == 1) begin : g_one
    assign diff_d = sl_sum[0];
  end else begin : g_many
    assign diff_d = {sl_sum[N-1], g_stg[N-1].g_body.res_q};
  end

  // Output payload only loads real transactions so bubbles never disturb the
  // reset-cleared values; c_q resets high so Borrow reads 0 out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      diff_q  <= '0;
      c_q     <= 1'b1;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else if (adv && vld_pipe[N-1]) begin
      diff_q  <= diff_d;
      c_q     <= sl_cout[N-1];
      a_msb_q <= g_stg[N-1].a_q[SLICE-1];
      b_msb_q <= ~g_stg[N-1].nb_q[SLICE-1];
    end
  end

  assign bus.out_valid = vld_pipe[N];
  assign bus.Diff      = diff_q;
  assign bus.Borrow    = ~c_q;
  assign bus.Ovf       = (a_msb_q != b_msb_q) && (diff_q[WIDTH-1] != a_msb_q);
  assign bus.Zero      = vld_pipe[N] && (diff_q == '0);
endmodule
